// File: rtl/mem_arb_pkg.sv
// ------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the memory arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_e;

    localparam logic [31:0] SEPARATOR_DEFAULT = 32'h1000_0000;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ------------------------------------------------------------------
// mem_arbiter_if : fetch, data and shared-memory buses of the arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  I_Req_i;
    logic [DATA_WIDTH-1:0] I_Address_i;
    logic                  I_Gnt_o;
    logic                  I_Valid_o;
    logic [DATA_WIDTH-1:0] I_Data_o;

    logic                  D_Req_i;
    logic                  D_Write_i;
    logic [DATA_WIDTH-1:0] D_Address_i;
    logic [DATA_WIDTH-1:0] D_Write_Data_i;
    logic                  D_Gnt_o;
    logic                  D_Valid_o;
    logic                  D_Error_o;
    logic [DATA_WIDTH-1:0] D_Data_o;

    logic [DATA_WIDTH-1:0] Mem_Address_o;
    logic [DATA_WIDTH-1:0] Mem_Write_Data_o;
    logic                  Mem_Write_Enable_o;
    logic [DATA_WIDTH-1:0] Mem_Data_i;

    modport slave (
        input  I_Req_i, I_Address_i,
        input  D_Req_i, D_Write_i, D_Address_i, D_Write_Data_i,
        input  Mem_Data_i,
        output I_Gnt_o, I_Valid_o, I_Data_o,
        output D_Gnt_o, D_Valid_o, D_Error_o, D_Data_o,
        output Mem_Address_o, Mem_Write_Data_o, Mem_Write_Enable_o
    );

    modport master (
        output I_Req_i, I_Address_i,
        output D_Req_i, D_Write_i, D_Address_i, D_Write_Data_i,
        output Mem_Data_i,
        input  I_Gnt_o, I_Valid_o, I_Data_o,
        input  D_Gnt_o, D_Valid_o, D_Error_o, D_Data_o,
        input  Mem_Address_o, Mem_Write_Data_o, Mem_Write_Enable_o
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter : two-way round-robin grant with last-served pointer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       i_req_i,
    input  logic       d_req_i,
    output logic       i_gnt_o,
    output logic       d_gnt_o,
    output requester_e winner_o
);

    requester_e last_q;
    requester_e last_d;

    // On a tie the side that was not served last wins.
    always_comb begin
        i_gnt_o  = 1'b0;
        d_gnt_o  = 1'b0;
        winner_o = REQ_I;
        last_d   = last_q;
        if (en_i) begin
            if (i_req_i && (!d_req_i || last_q == REQ_D)) begin
                i_gnt_o  = 1'b1;
                winner_o = REQ_I;
                last_d   = REQ_I;
            end else if (d_req_i) begin
                d_gnt_o  = 1'b1;
                winner_o = REQ_D;
                last_d   = REQ_D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ------------------------------------------------------------------
// mem_arbiter : fetch/data round-robin front end to a shared memory
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SEPARATOR  = DATA_WIDTH'(SEPARATOR_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_e                state_q, state_d;
    requester_e            owner_q, owner_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  i_valid_q, i_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic                  d_error_q, d_error_d;
    logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
    logic [DATA_WIDTH-1:0] d_data_q, d_data_d;

    logic                  w_arb_en;
    logic                  w_i_gnt;
    logic                  w_d_gnt;
    requester_e            w_winner;
    logic [DATA_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_mem_we;

    assign w_arb_en = (state_q == IDLE) && !reset;

    rr_arbiter u_rr_arbiter (
        .clk      (clk),
        .reset    (reset),
        .en_i     (w_arb_en),
        .i_req_i  (bus.I_Req_i),
        .d_req_i  (bus.D_Req_i),
        .i_gnt_o  (w_i_gnt),
        .d_gnt_o  (w_d_gnt),
        .winner_o (w_winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        d_error_d   = 1'b0;
        i_data_d    = i_data_q;
        d_data_d    = d_data_q;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_i_gnt || w_d_gnt) begin
                    state_d = ACCESS;
                    owner_d = w_winner;
                    if (w_winner == REQ_I) begin
                        addr_d  = bus.I_Address_i;
                        write_d = 1'b0;
                        wdata_d = '0;
                    end else begin
                        addr_d  = bus.D_Address_i;
                        write_d = bus.D_Write_i;
                        wdata_d = bus.D_Write_Data_i;
                    end
                end
            end
            ACCESS: begin
                state_d     = IDLE;
                w_mem_addr  = addr_q;
                w_mem_wdata = wdata_q;
                // Gating with reset lets a reset during ACCESS abort the write.
                w_mem_we    = (owner_q == REQ_D) && write_q &&
                              (addr_q >= SEPARATOR) && !reset;
                if (owner_q == REQ_I) begin
                    i_valid_d = 1'b1;
                    i_data_d  = bus.Mem_Data_i;
                end else begin
                    d_valid_d = 1'b1;
                    d_data_d  = write_q ? '0 : bus.Mem_Data_i;
                    d_error_d = write_q && (addr_q < SEPARATOR);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= REQ_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_error_q <= 1'b0;
            i_data_q  <= '0;
            d_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            d_error_q <= d_error_d;
            i_data_q  <= i_data_d;
            d_data_q  <= d_data_d;
        end
    end

    assign bus.I_Gnt_o            = w_i_gnt;
    assign bus.D_Gnt_o            = w_d_gnt;
    assign bus.I_Valid_o          = i_valid_q;
    assign bus.I_Data_o           = i_data_q;
    assign bus.D_Valid_o          = d_valid_q;
    assign bus.D_Error_o          = d_error_q;
    assign bus.D_Data_o           = d_data_q;
    assign bus.Mem_Address_o      = w_mem_addr;
    assign bus.Mem_Write_Data_o   = w_mem_wdata;
    assign bus.Mem_Write_Enable_o = w_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ------------------------------------------------------------------
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a ROM/RAM model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int          DW  = 32;
    localparam logic [31:0] SEP = 32'h1000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .DATA_WIDTH (DW),
        .SEPARATOR  (SEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   wr_cnt     = 0;
    int   rom_wr_cnt = 0;

    logic [31:0] ram    [0:15] = '{default: 32'h7000_0000};
    logic [31:0] shadow [0:15] = '{default: 32'h7000_0000};

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h5000_0000 | {2'b00, a[31:2]};
    endfunction

    assign bus.Mem_Data_i = (bus.Mem_Address_o >= SEP) ? ram[bus.Mem_Address_o[5:2]]
                                                       : rom_word(bus.Mem_Address_o);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.Mem_Write_Enable_o) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.Mem_Address_o < SEP) rom_wr_cnt <= rom_wr_cnt + 1;
            else ram[bus.Mem_Address_o[5:2]] <= bus.Mem_Write_Data_o;
        end
    end

    // Response side of the scoreboard: every pulse must match the oldest entry.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        got_d;
        logic [31:0] got_data;
        if (bus.I_Valid_o || bus.D_Valid_o) begin
            checks++;
            got_d    = bus.D_Valid_o;
            got_data = got_d ? bus.D_Data_o : bus.I_Data_o;
            if (bus.I_Valid_o && bus.D_Valid_o) begin
                errors++;
                $display("FAIL resp_both_valid: cycle %0d I_Valid and D_Valid both high", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: cycle %0d is_d=%0b data=%08h, none expected",
                         cyc, got_d, got_data);
            end else begin
                e = sb.pop_front();
                if (e.is_d !== got_d || e.data !== got_data || e.err !== bus.D_Error_o ||
                    e.due != cyc) begin
                    errors++;
                    $display("FAIL resp: got is_d=%0b data=%08h err=%0b cycle=%0d, expected is_d=%0b data=%08h err=%0b cycle=%0d",
                             got_d, got_data, bus.D_Error_o, cyc, e.is_d, e.data, e.err, e.due);
                end
            end
        end else begin
            checks++;
            if (bus.D_Error_o !== 1'b0) begin
                errors++;
                $display("FAIL d_error_idle: cycle %0d D_Error_o=%0b expected 0", cyc, bus.D_Error_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, hold it until granted (bounded), drop it the cycle after.
    task automatic issue(input bit is_d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, output int s, output int g);
        g = -1;
        tick();
        s = cyc;
        if (is_d) begin
            bus.D_Req_i = 1'b1; bus.D_Write_i = wr;
            bus.D_Address_i = addr; bus.D_Write_Data_i = wd;
        end else begin
            bus.I_Req_i = 1'b1; bus.I_Address_i = addr;
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            if (is_d ? bus.D_Gnt_o : bus.I_Gnt_o) begin
                g = cyc;
                break;
            end
            tick();
        end
        tick();
        if (is_d) bus.D_Req_i = 1'b0;
        else      bus.I_Req_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.I_Req_i = 1'b1;
        bus.D_Req_i = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({bus.I_Gnt_o, bus.D_Gnt_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt: got %02b expected 00", {bus.I_Gnt_o, bus.D_Gnt_o});
        end
        checks++;
        if ({bus.I_Valid_o, bus.D_Valid_o, bus.D_Error_o, bus.Mem_Write_Enable_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %04b expected 0000",
                     {bus.I_Valid_o, bus.D_Valid_o, bus.D_Error_o, bus.Mem_Write_Enable_o});
        end
        checks++;
        if ({bus.I_Data_o, bus.D_Data_o, bus.Mem_Address_o} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got I=%08h D=%08h MA=%08h expected 0",
                     bus.I_Data_o, bus.D_Data_o, bus.Mem_Address_o);
        end
        bus.I_Req_i = 1'b0;
        bus.D_Req_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_i_fetch();
        int s, g;
        issue(1'b0, 1'b0, 32'h0000_0004, 32'h0, s, g);
        sb.push_back('{is_d: 1'b0, data: rom_word(32'h4), err: 1'b0, due: g + 2});
        checks++;
        if (g != s) begin
            errors++;
            $display("FAIL ifetch_gnt: granted at cycle %0d expected %0d", g, s);
        end
        #1;
        checks++;
        if ({bus.Mem_Address_o, bus.Mem_Write_Enable_o, bus.I_Gnt_o, bus.D_Gnt_o} !== {32'h4, 3'b000}) begin
            errors++;
            $display("FAIL ifetch_access: got MA=%08h WE=%0b gnt=%0b%0b expected 00000004 0 00",
                     bus.Mem_Address_o, bus.Mem_Write_Enable_o, bus.I_Gnt_o, bus.D_Gnt_o);
        end
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ifetch_drain: %0d responses missing, expected 0", sb.size());
        end
    endtask

    task automatic test_d_write_read();
        int s, g, s2, g2, w0;
        w0 = wr_cnt;
        issue(1'b1, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, s, g);
        sb.push_back('{is_d: 1'b1, data: 32'h0, err: 1'b0, due: g + 2});
        #1;
        checks++;
        if ({bus.Mem_Write_Enable_o, bus.Mem_Address_o, bus.Mem_Write_Data_o} !==
            {1'b1, 32'h1000_0008, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL dwrite_access: got WE=%0b MA=%08h WD=%08h expected 1 10000008 deadbeef",
                     bus.Mem_Write_Enable_o, bus.Mem_Address_o, bus.Mem_Write_Data_o);
        end
        shadow[2] = 32'hDEAD_BEEF;
        issue(1'b1, 1'b0, 32'h1000_0008, 32'h0, s2, g2);
        sb.push_back('{is_d: 1'b1, data: shadow[2], err: 1'b0, due: g2 + 2});
        checks++;
        if (g2 != g + 2) begin
            errors++;
            $display("FAIL dread_pipelined: granted at cycle %0d expected %0d", g2, g + 2);
        end
        #1;
        checks++;
        if (bus.Mem_Write_Enable_o !== 1'b0) begin
            errors++;
            $display("FAIL dread_we: got %0b expected 0", bus.Mem_Write_Enable_o);
        end
        repeat (3) tick();
        checks++;
        if (wr_cnt - w0 != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL dwrite_count: writes=%0d pending=%0d expected 1 and 0", wr_cnt - w0, sb.size());
        end
    endtask

    task automatic test_rom_write();
        int s, g, w0;
        w0 = wr_cnt;
        issue(1'b1, 1'b1, 32'h0000_0010, 32'h0000_1234, s, g);
        sb.push_back('{is_d: 1'b1, data: 32'h0, err: 1'b1, due: g + 2});
        #1;
        checks++;
        if ({bus.Mem_Write_Enable_o, bus.Mem_Address_o} !== {1'b0, 32'h10}) begin
            errors++;
            $display("FAIL romwr_access: got WE=%0b MA=%08h expected 0 00000010",
                     bus.Mem_Write_Enable_o, bus.Mem_Address_o);
        end
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, s, g);
        sb.push_back('{is_d: 1'b1, data: rom_word(32'h10), err: 1'b0, due: g + 2});
        repeat (3) tick();
        checks++;
        if (rom_wr_cnt != 0 || wr_cnt != w0 || sb.size() != 0) begin
            errors++;
            $display("FAIL romwr_effect: rom_writes=%0d writes=%0d pending=%0d expected 0 0 0",
                     rom_wr_cnt, wr_cnt - w0, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ig, dg;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.I_Req_i = 1'b1; bus.I_Address_i = 32'h0000_0020;
        bus.D_Req_i = 1'b1; bus.D_Write_i = 1'b0; bus.D_Address_i = 32'h1000_0008;
        for (int k = 0; k < 8; k++) begin
            #1;
            ig = (k % 4 == 0);
            dg = (k % 4 == 2);
            checks++;
            if ({bus.I_Gnt_o, bus.D_Gnt_o} !== {ig, dg}) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: got %0b%0b expected %0b%0b",
                         k, bus.I_Gnt_o, bus.D_Gnt_o, ig, dg);
            end
            if (ig) sb.push_back('{is_d: 1'b0, data: rom_word(32'h20), err: 1'b0, due: cyc + 2});
            if (dg) sb.push_back('{is_d: 1'b1, data: shadow[2], err: 1'b0, due: cyc + 2});
            tick();
        end
        bus.I_Req_i = 1'b0;
        bus.D_Req_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d responses missing, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_abort();
        int s, g, w0;
        w0 = wr_cnt;
        issue(1'b1, 1'b1, 32'h1000_0008, 32'h1111_1111, s, g);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.Mem_Write_Enable_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_we: got %0b expected 0", bus.Mem_Write_Enable_o);
        end
        tick();
        reset = 1'b0;
        bus.I_Req_i = 1'b1; bus.I_Address_i = 32'h0000_000C;
        bus.D_Req_i = 1'b1; bus.D_Write_i = 1'b0; bus.D_Address_i = 32'h1000_0008;
        #1;
        checks++;
        if ({bus.I_Gnt_o, bus.D_Gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL abort_tie: got %0b%0b expected 10", bus.I_Gnt_o, bus.D_Gnt_o);
        end
        sb.push_back('{is_d: 1'b0, data: rom_word(32'hC), err: 1'b0, due: cyc + 2});
        tick();
        bus.I_Req_i = 1'b0;
        #1;
        checks++;
        if ({bus.I_Gnt_o, bus.D_Gnt_o} !== 2'b00) begin
            errors++;
            $display("FAIL access_no_gnt: got %0b%0b expected 00", bus.I_Gnt_o, bus.D_Gnt_o);
        end
        tick();
        #1;
        checks++;
        if ({bus.I_Gnt_o, bus.D_Gnt_o} !== 2'b01) begin
            errors++;
            $display("FAIL abort_dgnt: got %0b%0b expected 01", bus.I_Gnt_o, bus.D_Gnt_o);
        end
        sb.push_back('{is_d: 1'b1, data: shadow[2], err: 1'b0, due: cyc + 2});
        tick();
        bus.D_Req_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (wr_cnt != w0 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_effect: writes=%0d pending=%0d expected 0 0", wr_cnt - w0, sb.size());
        end
    endtask

    initial begin
        bus.I_Req_i        = 1'b0;
        bus.I_Address_i    = '0;
        bus.D_Req_i        = 1'b0;
        bus.D_Write_i      = 1'b0;
        bus.D_Address_i    = '0;
        bus.D_Write_Data_i = '0;
        test_reset();
        test_i_fetch();
        test_d_write_read();
        test_rom_write();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all address and data buses.
REQ-002 Parameter SEPARATOR, default 32'h1000_0000: addresses below this are ROM (read-only); addresses at or above it are RAM.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with the ports as listed below.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 I_Req_i  input  1  instruction-fetch request; held until granted.
REQ-007 I_Address_i  input  DATA_WIDTH  fetch address.
REQ-008 I_Gnt_o  output  1  fetch request accepted this cycle.
REQ-009 I_Valid_o  output  1  fetch data valid, one-cycle pulse.
REQ-010 I_Data_o  output  DATA_WIDTH  fetched word.
REQ-011 D_Req_i, D_Write_i  input  1 each  data request; 1 = write, 0 = read.
REQ-012 D_Address_i, D_Write_Data_i  input  DATA_WIDTH each  data address and data to store.
REQ-013 D_Gnt_o, D_Valid_o, D_Error_o  output  1 each  grant, completion pulse, and illegal-write flag.
REQ-014 D_Data_o  output  DATA_WIDTH  load data.
REQ-015 Mem_Address_o, Mem_Write_Data_o  output  DATA_WIDTH each  address and write data to the shared memory system.
REQ-016 Mem_Write_Enable_o  output  1  write strobe to the shared memory system.
REQ-017 Mem_Data_i  input  DATA_WIDTH  combinational read data from the memory system.

Function
REQ-018 States: IDLE and ACCESS only.
REQ-019 IDLE, no request: stay in IDLE; drive all Mem_* outputs to 0.
REQ-020 IDLE, request present: select a winner and assert its Gnt_o combinationally in the same cycle (cycle N).
  - Latch the winner's address, write flag and write data.
  - Enter ACCESS at the next edge.
REQ-021 Both requesting: grant the requester not served last (round-robin). After reset, the last-served pointer is D, so I wins the first tie.
REQ-022 Single requester: grant it regardless of the pointer. The pointer updates to the winner on every grant.
REQ-023 ACCESS (cycle N+1): drive Mem_Address_o and Mem_Write_Data_o from the latched values; register Mem_Data_i into the response data register; return to IDLE.
REQ-024 Mem_Write_Enable_o = 1 in ACCESS only when all of the following hold:
  - the transaction is a D write;
  - address >= SEPARATOR;
  - reset = 0.
REQ-025 Response (cycle N+2): the winner's Valid_o pulses high for exactly one cycle with its Data_o.
  - D writes return D_Data_o = 0.
  - The other requester's Valid_o stays 0.
REQ-026 D write with address < SEPARATOR:
  - no memory write occurs;
  - at N+2, D_Valid_o = 1, D_Error_o = 1, D_Data_o = 0.
  D_Error_o is 0 in every other cycle.
REQ-027 Pipelining: IDLE may grant a new request in the same cycle as the previous response pulse. Peak throughput is one transaction per 2 cycles.
REQ-028 Gnt_o is never asserted in ACCESS; at most one Gnt_o is high in any cycle.
REQ-029 Requests arriving during ACCESS are held by the requester and arbitrated in the next IDLE cycle.
REQ-030 I_Data_o and D_Data_o hold their last value when Valid_o is 0.

Reset
REQ-031 While reset = 1, at the next edge:
  - state goes to IDLE;
  - pointer goes to D;
  - all Valid_o, Error_o and Data_o registers clear to 0.
REQ-032 Reset asserted during ACCESS aborts the transaction:
  - Mem_Write_Enable_o is forced to 0 in that cycle, so no write commits;
  - no Valid_o pulse follows.
REQ-033 While reset = 1, I_Gnt_o and D_Gnt_o SHALL be 0.

Structure
REQ-034 Shared package mem_arb_pkg SHALL hold:
  - the state enum (IDLE, ACCESS);
  - the requester enum (REQ_I, REQ_D);
  - the SEPARATOR default constant.
REQ-035 A sub-module rr_arbiter SHALL implement the 2-way round-robin grant logic and the last-served pointer. mem_arbiter SHALL contain the FSM, the latches and the response registers.

Verification
REQ-036 Scenario: I only, I_Address_i = 0x0000_0004 at cycle 0 -> I_Gnt_o at 0; Mem_Address_o = 0x0000_0004 at 1; I_Valid_o at 2 with I_Data_o = ROM[1].
REQ-037 Scenario: D write 0x1000_0008 <- 0xDEAD_BEEF, then D read 0x1000_0008 -> Mem_Write_Enable_o = 1 for exactly one cycle; the read returns 0xDEAD_BEEF with D_Error_o = 0.
REQ-038 Scenario: I and D requesting continuously from reset -> grants alternate I, D, I, D at cycles 0, 2, 4, 6; valid pulses arrive at 2, 4, 6, 8.
REQ-039 Scenario: D write 0x0000_0010 <- 0x1234 -> Mem_Write_Enable_o stays 0; D_Valid_o = 1 and D_Error_o = 1 at N+2; the ROM word is unchanged.
REQ-040 Scenario: reset asserted during ACCESS of a RAM write -> no write occurs (a read-back shows the old value); no Valid_o pulse; the next request is granted by I under the tie rule.
